uart_rx_core: RTL



---
 rtl/uart_rx_core.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   Oversampling 8N1-style UART receiver. The serial input is synchronized,
//   the start, data and stop bits are each sampled at their middle, and every
//   received byte is offered on a valid/ready stream. A stop bit sampled low
//   raises a one-cycle frame_err pulse. A byte that completes while the output
//   slot is still full raises a one-cycle overrun pulse.
//
// Ports
//   clk        in   1          system clock, all logic on posedge
//   rst_n      in   1          synchronous reset, active-low
//   rx_i       in   1          asynchronous serial input, idle high
//   m_data     out  DATA_BITS  received byte (LSB arrives first on the line)
//   m_valid    out  1          m_data valid; held until accepted
//   m_ready    in   1          downstream accepts on m_valid & m_ready
//   frame_err  out  1          1-cycle pulse: stop bit sampled 0
//   overrun    out  1          1-cycle pulse: byte completed while slot full
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int DIV   = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(DATA_BITS - 1);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_core: CLK_FREQ_HZ/(BAUD*OVERSAMPLE) must be >= 1");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_os
        $error("uart_rx_core: OVERSAMPLE must be even and >= 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_db
        $error("uart_rx_core: DATA_BITS must be 5..9");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_q,     state_d;
    logic                 sync1_q,     sync1_d;
    logic                 rx_s_q,      rx_s_d;
    logic [CNT_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [SC_W-1:0]      sc_q,        sc_d;
    logic [BC_W-1:0]      bc_q,        bc_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] m_data_q,    m_data_d;
    logic                 m_valid_q,   m_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 tick;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_i;
        rx_s_d      = sync1_q;
        sc_d        = sc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        tick       = (tick_cnt_q == DIV_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        // Consumer takes the current byte; a delivery below may refill the
        // slot in the same cycle.
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    // Restart the tick divider so sample points line up with
                    // the falling edge rather than a free-running phase.
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    sc_d       = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (sc_q == SC_HALF) begin
                        if (rx_s_q) begin
                            state_d = ST_IDLE;  // too short to be a start bit
                        end else begin
                            state_d = ST_DATA;
                            sc_d    = '0;
                            bc_d    = '0;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d    = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bc_q == BC_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            bc_d = bc_q + 1'b1;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        if (rx_s_q) begin
                            // Return to IDLE at mid-stop so a start bit that
                            // immediately follows is caught on its edge.
                            state_d = ST_IDLE;
                            if (!m_valid_q || m_ready) begin
                                m_data_d  = shift_q;
                                m_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                // A line held low must go idle before another frame starts.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            tick_cnt_q  <= '0;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            tick_cnt_q  <= tick_cnt_d;
            sc_q        <= sc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
